// File: rtl/clock_div_pkg.sv
// Shared types and helpers for the clock-enable divider bank.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package clock_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    // Period below MIN_DIV is raised to MIN_DIV.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    endfunction

    // High time is capped so every period keeps at least one low cycle.
    // d_clamped must already have passed through clamp_div.
    function automatic logic [31:0] clamp_high(input logic [31:0] h, input logic [31:0] d_clamped);
        return (h > d_clamped - 32'd1) ? d_clamped - 32'd1 : h;
    endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: IDLE -> PHASE -> RUN -> DRAIN FSM with period counter and shadow registers.
// Latency: outputs registered; first tick on the enable edge (phase=0) or phase cycles later.
// Backpressure: none; free-running once enabled, stops only at a period boundary.
// Ports: clock/reset (sync, active-high); align (only with CLOCK_DIV_ALIGN_EN);
//        enable, div, high, phase in; out, tick, busy registered out.
module clock_div_channel
    import clock_div_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
`ifdef CLOCK_DIV_ALIGN_EN
    input  logic             align,
`endif
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] high,
    input  logic [DIV_W-1:0] phase,
    output logic             out,
    output logic             tick,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, div_sh, high_sh, phase_sh, ph_cnt;
    logic [DIV_W-1:0] div_c, high_c, cnt_nxt;
    logic             wrap, align_req;
    logic             load, ph_load, ph_dec, step_cnt, stop;

`ifdef CLOCK_DIV_ALIGN_EN
    assign align_req = align;
`else
    assign align_req = 1'b0;
`endif

    // Clamped views of the live inputs; they only matter at the instants they are sampled.
    assign div_c   = DIV_W'(clamp_div(32'(div)));
    assign high_c  = DIV_W'(clamp_high(32'(high), 32'(div_c)));
    assign cnt_nxt = cnt + DIV_W'(1);
    assign wrap    = (cnt == div_sh - DIV_W'(1));

    // load: start a fresh period (cnt=0, resample shadows, tick).
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ph_load   = 1'b0;
        ph_dec    = 1'b0;
        step_cnt  = 1'b0;
        stop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    if (phase == '0) begin
                        state_nxt = ST_RUN;
                        load      = 1'b1;
                    end else begin
                        state_nxt = ST_PHASE;
                        ph_load   = 1'b1;
                    end
                end
            end
            ST_PHASE: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (align_req) begin
                    ph_load = 1'b1;
                end else if (ph_cnt == '0) begin
                    state_nxt = ST_RUN;
                    load      = 1'b1;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                // Align wins over a coincident wrap so only one tick is produced.
                if (align_req) begin
                    load      = 1'b1;
                    state_nxt = (state == ST_RUN && enable) ? ST_RUN : ST_DRAIN;
                end else if (wrap) begin
                    if (enable) begin
                        state_nxt = ST_RUN;
                        load      = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        stop      = 1'b1;
                    end
                end else begin
                    // Dropping enable mid-period lets the period finish untouched.
                    step_cnt  = 1'b1;
                    state_nxt = enable ? ST_RUN : ST_DRAIN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            div_sh   <= '0;
            high_sh  <= '0;
            phase_sh <= '0;
            ph_cnt   <= '0;
            out      <= 1'b0;
            tick     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            tick  <= load;

            if (state == ST_IDLE && enable) begin
                phase_sh <= phase;
            end

            // Countdown of p-1..0 puts the RUN entry exactly p edges after the start edge.
            if (ph_load) begin
                ph_cnt <= ((state == ST_IDLE) ? phase : phase_sh) - DIV_W'(1);
            end else if (ph_dec) begin
                ph_cnt <= ph_cnt - DIV_W'(1);
            end

            if (load) begin
                cnt     <= '0;
                div_sh  <= div_c;
                high_sh <= high_c;
                out     <= (high_c != '0);
            end else if (step_cnt) begin
                cnt <= cnt_nxt;
                out <= (cnt_nxt < high_sh);
            end else if (stop) begin
                cnt <= '0;
                out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_div_bank.sv
// Bank of N_CH independent clock-enable dividers (period, high time, start phase, period tick).
// Latency: registered outputs; see clock_div_channel for per-channel timing.
// Backpressure: none; channels never stall each other.
// Ports: clock, reset (sync, active-high); ch_align only when CLOCK_DIV_ALIGN_EN is defined;
//        ch_enable[N_CH]; ch_div/ch_high/ch_phase packed N_CH*DIV_W (channel i at [i*DIV_W +: DIV_W]);
//        ch_out, ch_tick, ch_busy [N_CH] registered outputs.
module clock_div_bank
    import clock_div_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DIV_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef CLOCK_DIV_ALIGN_EN
    input  logic                  ch_align,
`endif
    input  logic [N_CH-1:0]       ch_enable,
    input  logic [N_CH*DIV_W-1:0] ch_div,
    input  logic [N_CH*DIV_W-1:0] ch_high,
    input  logic [N_CH*DIV_W-1:0] ch_phase,
    output logic [N_CH-1:0]       ch_out,
    output logic [N_CH-1:0]       ch_tick,
    output logic [N_CH-1:0]       ch_busy
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clock_div_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
`ifdef CLOCK_DIV_ALIGN_EN
            .align  (ch_align),
`endif
            .enable (ch_enable[i]),
            .div    (ch_div[i*DIV_W +: DIV_W]),
            .high   (ch_high[i*DIV_W +: DIV_W]),
            .phase  (ch_phase[i*DIV_W +: DIV_W]),
            .out    (ch_out[i]),
            .tick   (ch_tick[i]),
            .busy   (ch_busy[i])
        );
    end

endmodule
